// File: rtl/nes_bus_pkg.sv
// Shared NES bus constants and the oam_dma state encoding,
// used by the DMA engine, the bus mux and test code.
package nes_bus_pkg;

  localparam logic [15:0] DEFAULT_DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] DEFAULT_OAM_DATA_ADDR = 16'h2004;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: snoops CPU writes to the DMA register, halts the CPU,
// then copies 256 bytes from page {data,8'h00} into the PPU OAM port.
// Ports: i_clk, i_reset_n (sync, active-low), i_cpu_rw/i_cpu_address/
//   i_cpu_data (snooped CPU bus), i_data (bus read data),
//   o_cpu_halt, o_bus_own, o_rw, o_address, o_data, o_active.
// Option OAM_DMA_DEBUG_EN adds o_debug_state, o_debug_index, o_debug_error.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DEFAULT_DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = DEFAULT_OAM_DATA_ADDR
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  input  logic [7:0]  i_data,
`ifdef OAM_DMA_DEBUG_EN
  output logic [2:0]  o_debug_state,
  output logic [7:0]  o_debug_index,
  output logic        o_debug_error,
`endif
  output logic        o_cpu_halt,
  output logic        o_bus_own,
  output logic        o_rw,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  output logic        o_active
);

  dma_state_t state;
  dma_state_t state_next;
  logic [7:0] page;
  logic [7:0] index;
  logic [7:0] data;
  logic       parity;
  logic       trigger;
  logic       illegal;

  assign trigger = (i_cpu_rw == RW_WRITE) &&
                   (i_cpu_address == DMA_REG_ADDR);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state  <= ST_IDLE;
      page   <= 8'h00;
      index  <= 8'h00;
      data   <= 8'h00;
      parity <= 1'b0;
    end else begin
      state  <= state_next;
      parity <= ~parity;
      if (state == ST_IDLE && trigger) begin
        page  <= i_cpu_data;
        index <= 8'h00;
      end
      if (state == ST_READ) begin
        data <= i_data;
      end
      // 8-bit wrap is harmless: FF ends the transfer.
      if (state == ST_WRITE) begin
        index <= index + 8'h01;
      end
    end
  end

  always_comb begin
    state_next = state;
    illegal    = 1'b0;
    o_cpu_halt = 1'b0;
    o_bus_own  = 1'b0;
    o_active   = 1'b0;
    o_rw       = RW_READ;
    o_address  = 16'h0000;
    o_data     = 8'h00;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        o_cpu_halt = 1'b1;
        o_active   = 1'b1;
        // Odd phase needs one extra cycle to land reads on get cycles.
        state_next = parity ? ST_ALIGN : ST_READ;
      end
      ST_ALIGN: begin
        o_cpu_halt = 1'b1;
        o_active   = 1'b1;
        state_next = ST_READ;
      end
      ST_READ: begin
        o_cpu_halt = 1'b1;
        o_active   = 1'b1;
        o_bus_own  = 1'b1;
        o_rw       = RW_READ;
        o_address  = {page, index};
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        o_cpu_halt = 1'b1;
        o_active   = 1'b1;
        o_bus_own  = 1'b1;
        o_rw       = RW_WRITE;
        o_address  = OAM_DATA_ADDR;
        o_data     = data;
        state_next = (index == 8'hFF) ? ST_IDLE : ST_READ;
      end
      default: begin
        illegal    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef OAM_DMA_DEBUG_EN
  assign o_debug_state = state;
  assign o_debug_index = index;
  assign o_debug_error = illegal;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma: reset, even/odd triggers,
// data path, page wrap, ignored triggers and mid-transfer reset.
module tb_oam_dma;

  logic        clk;
  logic        reset_n;
  logic        cpu_rw;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data;
  logic [7:0]  bus_data;
  logic        cpu_halt;
  logic        bus_own;
  logic        rw;
  logic [15:0] address;
  logic [7:0]  data;
  logic        active;
`ifdef OAM_DMA_DEBUG_EN
  logic [2:0]  dbg_state;
  logic [7:0]  dbg_index;
  logic        dbg_error;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;

  oam_dma dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_cpu_rw      (cpu_rw),
    .i_cpu_address (cpu_address),
    .i_cpu_data    (cpu_data),
    .i_data        (bus_data),
`ifdef OAM_DMA_DEBUG_EN
    .o_debug_state (dbg_state),
    .o_debug_index (dbg_index),
    .o_debug_error (dbg_error),
`endif
    .o_cpu_halt    (cpu_halt),
    .o_bus_own     (bus_own),
    .o_rw          (rw),
    .o_address     (address),
    .o_data        (data),
    .o_active      (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: every byte reads back as its low address ^ A5.
  assign bus_data = address[7:0] ^ 8'hA5;

  // Cycle-phase model: count of non-reset edges since reset.
  always @(posedge clk) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  task automatic do_transfer(
    input  logic [7:0]  page,
    input  bit          want_par,
    input  bit          retrig,
    output int          halt_n,
    output int          first_k,
    output logic [15:0] first_a,
    output logic [15:0] last_a,
    output int          addr_err,
    output int          data_err,
    output int          n_wr,
    output bit          tmo
  );
    int k;
    int n_rd;
    logic [7:0] idx;
    halt_n = 0; first_k = -1; first_a = 16'hxxxx;
    last_a = 16'hxxxx; addr_err = 0; data_err = 0;
    n_rd = 0; n_wr = 0; tmo = 0; k = 0; idx = 8'h00;
    @(negedge clk);
    // Phase in HALT equals edge parity after the trigger edge.
    if (((edges + 1) % 2) != int'(want_par)) @(negedge clk);
    cpu_rw = 1'b0; cpu_address = 16'h4014; cpu_data = page;
    @(posedge clk); #1;
    cpu_rw = 1'b1; cpu_address = 16'h0000; cpu_data = 8'h00;
    forever begin
      @(negedge clk);
      k++;
      if (retrig && k == 10) begin
        cpu_rw = 1'b0; cpu_address = 16'h4014; cpu_data = 8'h07;
      end else if (retrig && k == 11) begin
        cpu_rw = 1'b1; cpu_address = 16'h0000; cpu_data = 8'h00;
      end
      if (cpu_halt) halt_n++;
      if (bus_own && rw) begin
        if (n_rd == 0) begin first_k = k; first_a = address; end
        last_a = address;
        if (address !== {page, idx}) addr_err++;
        n_rd++;
      end
      if (bus_own && !rw) begin
        if (address !== 16'h2004 || data !== (idx ^ 8'hA5)) data_err++;
        idx++;
        n_wr++;
      end
      if (!active) break;
      if (k > 700) begin tmo = 1; break; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cpu_rw = 1'b1; cpu_address = 16'h0000; cpu_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks += 5;
    if (cpu_halt !== 1'b0) begin n_fail++;
      $display("FAIL reset_halt got %b want 0", cpu_halt); end
    if (bus_own !== 1'b0) begin n_fail++;
      $display("FAIL reset_bus_own got %b want 0", bus_own); end
    if (rw !== 1'b1) begin n_fail++;
      $display("FAIL reset_rw got %b want 1", rw); end
    if (address !== 16'h0000) begin n_fail++;
      $display("FAIL reset_address got %h want 0000", address); end
    if (active !== 1'b0) begin n_fail++;
      $display("FAIL reset_active got %b want 0", active); end
    reset_n = 1'b1;
  endtask

  task automatic test_trigger(input logic [7:0] page,
                              input bit par, input bit retrig,
                              input string nm);
    int h, fk, ae, de, nw;
    logic [15:0] fa, la;
    bit t;
    int exp_h, exp_k;
    exp_h = par ? 514 : 513;
    exp_k = par ? 3 : 2;
    do_transfer(page, par, retrig, h, fk, fa, la, ae, de, nw, t);
    n_checks += 7;
    if (t) begin n_fail++;
      $display("FAIL %s_timeout transfer never ended", nm); end
    if (h !== exp_h) begin n_fail++;
      $display("FAIL %s_halt_cycles got %0d want %0d", nm, h, exp_h); end
    if (fk !== exp_k) begin n_fail++;
      $display("FAIL %s_first_read_cycle got %0d want %0d", nm, fk, exp_k); end
    if (fa !== {page, 8'h00}) begin n_fail++;
      $display("FAIL %s_first_addr got %h want %h", nm, fa, {page, 8'h00}); end
    if (la !== {page, 8'hFF}) begin n_fail++;
      $display("FAIL %s_last_addr got %h want %h", nm, la, {page, 8'hFF}); end
    if (ae !== 0 || nw !== 256) begin n_fail++;
      $display("FAIL %s_read_seq addr_errs %0d writes %0d want 0/256",
               nm, ae, nw); end
    if (de !== 0) begin n_fail++;
      $display("FAIL %s_write_data errs %0d want 0", nm, de); end
  endtask

  task automatic test_even;
    test_trigger(8'h02, 1'b0, 1'b0, "even");
  endtask

  task automatic test_odd;
    test_trigger(8'h02, 1'b1, 1'b0, "odd");
  endtask

  task automatic test_retrigger_ignored;
    test_trigger(8'h31, 1'b0, 1'b1, "retrig");
  endtask

  task automatic test_no_page_carry;
    @(negedge clk);
    cpu_rw = 1'b1; cpu_address = 16'h4014; cpu_data = 8'h55;
    @(negedge clk);
    cpu_address = 16'h0000; cpu_data = 8'h00;
    @(negedge clk);
    n_checks += 2;
    if (active !== 1'b0) begin n_fail++;
      $display("FAIL read_no_trigger_active got %b want 0", active); end
    if (cpu_halt !== 1'b0) begin n_fail++;
      $display("FAIL read_no_trigger_halt got %b want 0", cpu_halt); end
    test_trigger(8'hFF, 1'b1, 1'b0, "page_ff");
    n_checks += 1;
    if (address !== 16'h0000 || bus_own !== 1'b0) begin n_fail++;
      $display("FAIL page_ff_idle addr %h own %b want 0000/0",
               address, bus_own); end
  endtask

  task automatic test_reset_mid;
    int k;
    bit hit;
    hit = 0;
    @(negedge clk);
    cpu_rw = 1'b0; cpu_address = 16'h4014; cpu_data = 8'h03;
    @(posedge clk); #1;
    cpu_rw = 1'b1; cpu_address = 16'h0000; cpu_data = 8'h00;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus_own && rw && address == 16'h0340) begin hit = 1; break; end
    end
    n_checks += 1;
    if (!hit) begin n_fail++;
      $display("FAIL midreset_reach got none want read 0340"); end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (cpu_halt !== 1'b0) begin n_fail++;
      $display("FAIL midreset_halt got %b want 0", cpu_halt); end
    if (active !== 1'b0) begin n_fail++;
      $display("FAIL midreset_active got %b want 0", active); end
    if (bus_own !== 1'b0 || address !== 16'h0000) begin n_fail++;
      $display("FAIL midreset_bus own %b addr %h want 0/0000",
               bus_own, address); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 1;
    if (active !== 1'b0) begin n_fail++;
      $display("FAIL midreset_no_resume got %b want 0", active); end
    test_trigger(8'h05, 1'b0, 1'b0, "restart");
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_rw = 1'b1; cpu_address = 16'h0000; cpu_data = 8'h00;
    test_reset();
    test_even();
    test_odd();
    test_retrigger_ignored();
    test_no_page_carry();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
